// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose:
//   Consumes GRF rs/rt read data for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//   Multiply and divide ops run for MUL_CYCLES/DIV_CYCLES edges and then
//   update HI/LO. MTHI/MTLO write at the issuing edge.
//   busy feeds the hazard logic so dependent MDU instructions stall.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (aborts any operation)
//   start    in   request strobe, sampled with mdu_op/rs_data/rt_data
//   mdu_op   in   [3:0] 0 NOP 1 MULT 2 MULTU 3 DIV 4 DIVU 5 MTHI 6 MTLO
//                 7 MADD 8 MADDU (7/8 only with the option), others NOP
//   rs_data  in   [31:0] operand A (dividend / multiplicand / MTHI-MTLO source)
//   rt_data  in   [31:0] operand B (divisor / multiplier)
//   busy     out  operation in flight
//   hi, lo   out  [31:0] HI/LO registers
//
// Option macro: MDU_MADD_EN enables MADD/MADDU (multiply-accumulate).

module mdu_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic        busy_q;
  logic [15:0] cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;

  // Request decode on the issue-side inputs
  logic is_long, is_div;
  always_comb begin
    is_div  = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
    is_long = is_div || (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`ifdef MDU_MADD_EN
    if ((mdu_op == OP_MADD) || (mdu_op == OP_MADDU)) is_long = 1'b1;
`endif
  end

  // Products from latched operands; sign-extending to 64 bits makes the
  // low 64 bits of the unsigned product equal the signed product.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // One unsigned divider shared by DIV and DIVU: DIV works on magnitudes
  // and restores signs afterwards. 0x80000000 has magnitude 2^31 as an
  // unsigned value, so MIN/-1 naturally yields 0x80000000 remainder 0.
  logic        div_signed, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, safe_b, q_mag, r_mag, quo, rem;
  always_comb begin
    div_signed = (op_q == OP_DIV);
    neg_a      = div_signed & a_q[31];
    neg_b      = div_signed & b_q[31];
    mag_a      = neg_a ? (32'd0 - a_q) : a_q;
    mag_b      = neg_b ? (32'd0 - b_q) : b_q;
    // Divisor 0 never updates HI/LO; substitute 1 to keep the datapath defined
    safe_b     = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag      = mag_a / safe_b;
    r_mag      = mag_a % safe_b;
    quo        = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem        = neg_a ? (32'd0 - r_mag) : r_mag;
  end

  // Next HI/LO value at completion; defaults to "unchanged"
  logic [63:0] hilo_d;
  always_comb begin
    hilo_d = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  hilo_d = prod_s;
      OP_MULTU: hilo_d = prod_u;
      OP_DIV, OP_DIVU: if (b_q != 32'd0) hilo_d = {rem, quo};
`ifdef MDU_MADD_EN
      // Accumulates onto the HI/LO present at the completion edge
      OP_MADD:  hilo_d = {hi_q, lo_q} + prod_s;
      OP_MADDU: hilo_d = {hi_q, lo_q} + prod_u;
`endif
      default:  hilo_d = {hi_q, lo_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_long) begin
              op_q    <= mdu_op;
              a_q     <= rs_data;
              b_q     <= rt_data;
              cnt_q   <= is_div ? 16'(DIV_CYCLES) : 16'(MUL_CYCLES);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else if (mdu_op == OP_MTHI) begin
              hi_q <= rs_data;
            end else if (mdu_op == OP_MTLO) begin
              lo_q <= rs_data;
            end
          end
        end
        RUN: begin
          // start is ignored here; the stall logic keeps it from happening
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            {hi_q, lo_q} <= hilo_d;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
